// File: rtl/dp_ram_arbiter.sv
// Round-robin arbiter sharing one RAM data port between two OBI-style requesters.
// Optional grant-stall injection is enabled by defining DP_RAM_ARB_STALL_EN.
module dp_ram_arbiter #(
    parameter int ADDR_WIDTH = 22,
    parameter int NUM_REQ    = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_REQ-1:0]            req_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr_i,
    input  logic [NUM_REQ-1:0]            we_i,
    input  logic [NUM_REQ*4-1:0]          be_i,
    input  logic [NUM_REQ*32-1:0]         wdata_i,
    output logic [NUM_REQ-1:0]            gnt_o,
    output logic [NUM_REQ-1:0]            rvalid_o,
    output logic [31:0]                   rdata_o,
    output logic                          ram_en_o,
    output logic [ADDR_WIDTH-1:0]         ram_addr_o,
    output logic                          ram_we_o,
    output logic [3:0]                    ram_be_o,
    output logic [31:0]                   ram_wdata_o,
    input  logic [31:0]                   ram_rdata_i
);

    generate
        if (NUM_REQ != 2) begin : g_bad_num_req
            $fatal(1, "dp_ram_arbiter: NUM_REQ must be 2");
        end
    endgenerate

    logic stall;

`ifdef DP_RAM_ARB_STALL_EN
    // Fibonacci LFSR, taps 16/14/13/11; a zero low pair suppresses the grant.
    logic [15:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign stall = (lfsr_q[1:0] == 2'b00);
`else
    assign stall = 1'b0;
`endif

    logic last_q, last_d;
    logic rsp_valid_q, rsp_valid_d;
    logic rsp_id_q, rsp_id_d;
    logic gnt_idx;
    logic [1:0] gnt;

    always_comb begin
        gnt     = 2'b00;
        gnt_idx = 1'b0;
        // Reset gates the grant combinationally so nothing reaches the RAM while held.
        if (!rst_i && !stall) begin
            if (req_i[0] && req_i[1]) begin
                gnt_idx = ~last_q;
                gnt     = gnt_idx ? 2'b10 : 2'b01;
            end else if (req_i[0]) begin
                gnt = 2'b01;
            end else if (req_i[1]) begin
                gnt_idx = 1'b1;
                gnt     = 2'b10;
            end
        end
        last_d      = (|gnt) ? gnt_idx : last_q;
        rsp_valid_d = |gnt;
        rsp_id_d    = gnt_idx;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_q      <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
        end else begin
            last_q      <= last_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
        end
    end

    assign gnt_o    = gnt;
    assign ram_en_o = |gnt;

    // With no grant gnt_idx is 0, so requester 0's fields sit on the port.
    always_comb begin
        ram_addr_o  = gnt_idx ? addr_i[ADDR_WIDTH +: ADDR_WIDTH] : addr_i[0 +: ADDR_WIDTH];
        ram_we_o    = gnt_idx ? we_i[1] : we_i[0];
        ram_be_o    = gnt_idx ? be_i[7:4] : be_i[3:0];
        ram_wdata_o = gnt_idx ? wdata_i[63:32] : wdata_i[31:0];
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_rvalid
            assign rvalid_o[gi] = rsp_valid_q && (int'(rsp_id_q) == gi);
        end
    endgenerate

    assign rdata_o = ram_rdata_i;

endmodule

// File: tb/tb_dp_ram_arbiter.sv
// Directed bench for dp_ram_arbiter with a behavioural RAM on port B; a randomised
// stall run replaces the directed steps when DP_RAM_ARB_STALL_EN is defined.
module tb_dp_ram_arbiter;

    localparam int AW = 22;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    req;
    logic [AW-1:0] a  [2];
    logic [1:0]    we;
    logic [3:0]    be [2];
    logic [31:0]   wd [2];
    logic [1:0]    gnt_o, rvalid_o;
    logic [31:0]   rdata_o, ram_wdata_o, ram_rdata;
    logic          ram_en_o, ram_we_o;
    logic [AW-1:0] ram_addr_o;
    logic [3:0]    ram_be_o;
    logic [31:0]   mem [256];

    int total = 0;
    int fails = 0;

    always #5 clk = ~clk;

    dp_ram_arbiter #(.ADDR_WIDTH(AW), .NUM_REQ(2)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_i       (req),
        .addr_i      ({a[1], a[0]}),
        .we_i        (we),
        .be_i        ({be[1], be[0]}),
        .wdata_i     ({wd[1], wd[0]}),
        .gnt_o       (gnt_o),
        .rvalid_o    (rvalid_o),
        .rdata_o     (rdata_o),
        .ram_en_o    (ram_en_o),
        .ram_addr_o  (ram_addr_o),
        .ram_we_o    (ram_we_o),
        .ram_be_o    (ram_be_o),
        .ram_wdata_o (ram_wdata_o),
        .ram_rdata_i (ram_rdata)
    );

    // Read-old RAM with one-cycle latency.
    always @(posedge clk) begin
        if (ram_en_o) begin
            ram_rdata <= mem[ram_addr_o[9:2]];
            if (ram_we_o) begin
                for (int b = 0; b < 4; b++) begin
                    if (ram_be_o[b]) mem[ram_addr_o[9:2]][8*b +: 8] <= ram_wdata_o[8*b +: 8];
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-16s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic set_req(input int r, input logic [AW-1:0] ad, input logic w,
                           input logic [3:0] b, input logic [31:0] d);
        a[r] = ad; we[r] = w; be[r] = b; wd[r] = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

`ifdef DP_RAM_ARB_STALL_EN
    logic [31:0] mref [16];
    int issued = 0, busy = 0, stalls = 0;
    logic exp_v = 1'b0, exp_rd = 1'b0, exp_id = 1'b0;
    logic [31:0] exp_d = '0;
    logic [1:0]  gnt_seen;
    int k;
`endif

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        rst = 1'b1;
        req = 2'b11;
        set_req(0, 22'h100, 1'b0, 4'hF, 32'h0);
        set_req(1, 22'h104, 1'b0, 4'hF, 32'h0);
        step(); step();
        @(negedge clk);
        chk("rst_gnt", 32'(gnt_o), 32'h0);
        chk("rst_ram_en", 32'(ram_en_o), 32'h0);
        chk("rst_rvalid", 32'(rvalid_o), 32'h0);
        step();
        rst = 1'b0;

`ifdef DP_RAM_ARB_STALL_EN
        req = 2'b00;
        for (int i = 0; i < 16; i++) mref[i] = '0;
        for (int cyc = 0; cyc < 20000 && (issued < 1000 || req != 2'b00); cyc++) begin
            for (int r = 0; r < 2; r++) begin
                if (!req[r] && issued < 1000 && $urandom_range(0, 1) == 1) begin
                    set_req(r, 22'h300 + 22'(4 * $urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                            4'($urandom_range(1, 15)), $urandom);
                    req[r] = 1'b1;
                    issued++;
                end
            end
            @(negedge clk);
            chk("stall_rvalid", 32'(rvalid_o), exp_v ? (32'h1 << exp_id) : 32'h0);
            if (exp_v && exp_rd) chk("stall_rdata", rdata_o, exp_d);
            if ((gnt_o & ~req) != 2'b00) chk("stall_gnt_noreq", 32'(gnt_o), 32'(gnt_o & req));
            if (req != 2'b00) busy++;
            if (req != 2'b00 && gnt_o == 2'b00) stalls++;
            gnt_seen = gnt_o;
            exp_v    = |gnt_o;
            if (|gnt_o) begin
                exp_id = gnt_o[1];
                exp_rd = !we[exp_id];
                k      = int'(a[exp_id][5:2]);
                exp_d  = mref[k];
                if (we[exp_id]) begin
                    for (int b = 0; b < 4; b++)
                        if (be[exp_id][b]) mref[k][8*b +: 8] = wd[exp_id][8*b +: 8];
                end
            end
            step();
            req = req & ~gnt_seen;
        end
        chk("stall_all_granted", 32'(req), 32'h0);
        chk("stall_issued", 32'(issued), 32'd1000);
        chk("stall_frac_ok", 32'((stalls * 100 >= busy * 15) && (stalls * 100 <= busy * 35)), 32'h1);
`else
        // Tie-break straight out of reset: 0,1,0,1.
        @(negedge clk);
        chk("tie_gnt0", 32'(gnt_o), 32'h1);
        chk("tie_addr0", 32'(ram_addr_o), 32'h100);
        step(); @(negedge clk);
        chk("tie_gnt1", 32'(gnt_o), 32'h2);
        chk("tie_rv1", 32'(rvalid_o), 32'h1);
        chk("tie_addr1", 32'(ram_addr_o), 32'h104);
        step(); @(negedge clk);
        chk("tie_gnt2", 32'(gnt_o), 32'h1);
        chk("tie_rv2", 32'(rvalid_o), 32'h2);
        step(); @(negedge clk);
        chk("tie_gnt3", 32'(gnt_o), 32'h2);
        chk("tie_rv3", 32'(rvalid_o), 32'h1);
        step();
        req = 2'b00;
        @(negedge clk);
        chk("idle_gnt", 32'(gnt_o), 32'h0);
        chk("idle_en", 32'(ram_en_o), 32'h0);
        chk("idle_addr_mux", 32'(ram_addr_o), 32'h100);
        chk("tie_rv4", 32'(rvalid_o), 32'h2);

        // Single write via 0 then read via 1.
        step();
        set_req(0, 22'h100, 1'b1, 4'hF, 32'hDEADBEEF);
        req = 2'b01;
        @(negedge clk);
        chk("wr_gnt", 32'(gnt_o), 32'h1);
        chk("wr_we", 32'(ram_we_o), 32'h1);
        chk("wr_wdata", ram_wdata_o, 32'hDEADBEEF);
        step();
        set_req(1, 22'h100, 1'b0, 4'hF, 32'h0);
        req = 2'b10;
        @(negedge clk);
        chk("rd_gnt", 32'(gnt_o), 32'h2);
        chk("rd_we", 32'(ram_we_o), 32'h0);
        chk("wr_rvalid", 32'(rvalid_o), 32'h1);
        step();
        req = 2'b00;
        @(negedge clk);
        chk("rd_rvalid", 32'(rvalid_o), 32'h2);
        chk("rd_rdata", rdata_o, 32'hDEADBEEF);

        // Byte enables; write then read of the same word granted in consecutive cycles.
        step();
        set_req(1, 22'h200, 1'b1, 4'hF, 32'h0);
        req = 2'b10;
        @(negedge clk);
        chk("be_pre_gnt", 32'(gnt_o), 32'h2);
        step();
        set_req(0, 22'h200, 1'b1, 4'b0101, 32'h11223344);
        set_req(1, 22'h200, 1'b0, 4'hF, 32'h0);
        req = 2'b11;
        @(negedge clk);
        chk("be_wr_gnt", 32'(gnt_o), 32'h1);
        chk("be_ram_be", 32'(ram_be_o), 32'h5);
        step();
        req = 2'b10;
        @(negedge clk);
        chk("be_rd_gnt", 32'(gnt_o), 32'h2);
        chk("be_wr_rvalid", 32'(rvalid_o), 32'h1);
        step();
        req = 2'b00;
        @(negedge clk);
        chk("be_rd_rvalid", 32'(rvalid_o), 32'h2);
        chk("be_rdata", rdata_o, 32'h00220044);

        // Reset one cycle after a read grant drops its response.
        step();
        set_req(1, 22'h100, 1'b0, 4'hF, 32'h0);
        req = 2'b10;
        @(negedge clk);
        chk("mid_gnt", 32'(gnt_o), 32'h2);
        step();
        rst = 1'b1;
        set_req(0, 22'h104, 1'b0, 4'hF, 32'h0);
        req = 2'b11;
        @(negedge clk);
        chk("mid_rst_rvalid", 32'(rvalid_o), 32'h0);
        chk("mid_rst_gnt", 32'(gnt_o), 32'h0);
        chk("mid_rst_en", 32'(ram_en_o), 32'h0);
        step(); @(negedge clk);
        chk("mid_rst_rvalid2", 32'(rvalid_o), 32'h0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_gnt", 32'(gnt_o), 32'h1);
        chk("post_rst_rvalid", 32'(rvalid_o), 32'h0);
        step(); @(negedge clk);
        chk("post_rst_gnt2", 32'(gnt_o), 32'h2);
        chk("post_rst_rv", 32'(rvalid_o), 32'h1);
        step();
        req = 2'b00;
`endif
        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule

// File: doc/dp_ram_arbiter.md
# dp_ram_arbiter

Two-requester arbiter and sequencer in front of the data port (port B) of the testbench dual-port RAM. It lets the core's data interface and an auxiliary requester (loader, debug or DMA model) share the single RAM data port. Arbitration is round-robin on an OBI-style req/gnt/rvalid handshake. Responses return with the RAM's fixed one-cycle read latency. An optional compile-time feature injects pseudo-random grant stalls to stress the core's LSU.

## Interface

Parameters:
- ADDR_WIDTH, 22: byte address width, equal to the RAM address width.
- NUM_REQ, 2: number of requesters; fixed at 2. Any other value is a $fatal at elaboration.

Ports:
- clk_i  in  1  clock; all state updates on its rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- req_i  in  NUM_REQ  per-requester request.
- addr_i  in  NUM_REQ*ADDR_WIDTH  per-requester byte address; requester r occupies slice [r*ADDR_WIDTH +: ADDR_WIDTH].
- we_i  in  NUM_REQ  per-requester write enable.
- be_i  in  NUM_REQ*4  per-requester byte enables.
- wdata_i  in  NUM_REQ*32  per-requester write data.
- gnt_o  out  NUM_REQ  per-requester grant; combinational; one-hot or zero.
- rvalid_o  out  NUM_REQ  per-requester response valid; registered.
- rdata_o  out  32  response data; shared by both requesters; qualified by rvalid_o.
- ram_en_o  out  1  RAM port B enable.
- ram_addr_o  out  ADDR_WIDTH  RAM port B address.
- ram_we_o  out  1  RAM port B write enable.
- ram_be_o  out  4  RAM port B byte enables.
- ram_wdata_o  out  32  RAM port B write data.
- ram_rdata_i  in  32  RAM port B read data; valid one cycle after ram_en_o.

## Operation

- **Handshake:** a transfer occurs in a cycle where req_i[r] and gnt_o[r] are both high. Once req_i[r] is raised, the requester holds it and its addr/we/be/wdata stable until granted. The arbiter never grants a requester whose req_i is low.
- **Round-robin pointer:** register last_q, one bit, holding the index of the most recently granted requester.
  - Only one requester active: grant it.
  - Both active: grant requester !last_q.
  - last_q updates to the granted index on every grant; it holds when there is no grant.
- **RAM drive:** ram_en_o = |gnt_o. The ram_addr/we/be/wdata outputs mux the granted requester's fields. When there is no grant, they mux requester 0's fields with ram_en_o low.
- **Response tracking:** registers rsp_valid_q (1 bit) and rsp_id_q (1 bit) load |gnt_o and the granted index every cycle.
  - rvalid_o[r] = rsp_valid_q && rsp_id_q == r.
  - rdata_o = ram_rdata_i, passed through.
- **Write responses:** writes also receive rvalid; rdata_o is don't-care for a write response.
- **Pipelining:** at most one transfer per cycle in total. Back-to-back grants are allowed, including to the same requester, with no bubble.

## Timing

- **Grant to response:** grant in cycle N gives ram_en_o in N and rvalid_o in N+1, with rdata_o equal to the RAM contents as of N.
- **Grant path:** zero-cycle, combinational from req_i to gnt_o. There is no combinational path from req_i to rvalid_o.
- **While rst_i is high:**
  - gnt_o = 0, ram_en_o = 0, rvalid_o = 0.
  - last_q = 1, so requester 0 wins the first tie.
  - rsp_valid_q = 0, rsp_id_q = 0.
- **Reset mid-operation:** a response whose grant preceded reset assertion is dropped; no rvalid is produced for it. After reset deassertion the first grant is possible in the first clock edge cycle.
- **Simultaneous requests, same address:** ordering follows grant order. A read granted the cycle after a write to the same word returns the written data.
- **Address:** passed unmodified. Word alignment is done by the RAM.

## Configuration

- **Macro DP_RAM_ARB_STALL_EN, defined:** adds a 16-bit Fibonacci LFSR.
  - Polynomial x^16+x^14+x^13+x^11+1; reset value 16'hACE1; advances every cycle.
  - When lfsr[1:0] == 2'b00, gnt_o is forced to 0 for that cycle. This gives roughly 25% stall cycles.
  - During a stall, last_q and the response registers behave as for a no-grant cycle.
- **Macro not defined:** no LFSR exists and grants are never suppressed.

## Test plan

- **Single read:** write 0xDEADBEEF to 0x100 via requester 0, then read 0x100 via requester 1. Requires rvalid_o = 2'b10 exactly one cycle after the read grant, with rdata_o = 0xDEADBEEF.
- **Tie-break:** both requesters request continuously for 4 cycles after reset. Requires grants in order 0, 1, 0, 1 and rvalid_o following one cycle later in the same order.
- **Byte enables:** write 0x11223344 to 0x200 with be = 4'b0101, after the word was preloaded with 0. A subsequent read returns 0x00220044.
- **Reset mid-transfer:** assert rst_i in the cycle after a read grant. Requires rvalid_o = 0 throughout, gnt_o = 0 while in reset, and requester 0 granted first on a tie after release.
- **Stall mode (DP_RAM_ARB_STALL_EN defined):** 1000 random requests. Requires every request eventually granted, each rvalid exactly one cycle after its grant, data matching a reference model, and a stall-cycle fraction between 0.15 and 0.35.
